// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP histogram block: state encoding,
// default sizes and the image border coordinates.
package lbp_pkg;

  localparam int LBP_BINS  = 256;
  localparam int LBP_CNT_W = 14;

  localparam logic [6:0] BORDER_LO = 7'd0;
  localparam logic [6:0] BORDER_HI = 7'd127;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_DRAIN,
    ST_READ,
    ST_DONE
  } state_t;

  // Codes from the outermost ring of the image have no valid neighbourhood.
  function automatic logic is_border(input logic [13:0] addr);
    logic [6:0] row;
    logic [6:0] col;
    row = addr[13:7];
    col = addr[6:0];
    return (row == BORDER_LO) || (row == BORDER_HI) ||
           (col == BORDER_LO) || (col == BORDER_HI);
  endfunction

endpackage

// File: rtl/hist_bank.sv
// Histogram storage: bin array with a touched mask, so stale contents left
// over from a previous image read as zero without a clear sweep.
module hist_bank
  import lbp_pkg::*;
#(
  parameter int BINS  = LBP_BINS,
  parameter int CNT_W = LBP_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_bin,
  input  logic [7:0]       rd_bin,
  output logic [CNT_W-1:0] rd_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] mem [BINS];
  logic [BINS-1:0]  touched;
  logic [CNT_W-1:0] cur_count;
  logic [CNT_W-1:0] nxt_count;

  // Read-modify-write completes in one cycle, so back-to-back hits on the
  // same bin always see the previous increment.
  always_comb begin
    cur_count = touched[wr_bin] ? mem[wr_bin] : '0;
    nxt_count = (cur_count == CNT_MAX) ? CNT_MAX : cur_count + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      touched <= '0;
    end else if (wr_en) begin
      touched[wr_bin] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bin] <= nxt_count;
    end
  end

  assign rd_count = touched[rd_bin] ? mem[rd_bin] : '0;

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates codes from the LBP stage, drains the
// update pipeline, then streams all bins out with a valid/ready handshake.
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int BINS  = LBP_BINS,
  parameter int CNT_W = LBP_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic [CNT_W-1:0] pix_count,
  output logic             addr_err,
  output logic             hist_done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       LAST_BIN = 8'(BINS - 1);

  state_t           state;
  state_t           state_nxt;
  logic             drain_cnt;
  logic             s1_valid;
  logic [7:0]       s1_bin;
  logic             accept;
  logic             border;
  logic             beat;
  logic [CNT_W-1:0] rd_count;

  assign border = is_border(lbp_addr);
  assign accept = (state == ST_ACC) && lbp_valid;
  assign beat   = (state == ST_READ) && hist_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:   if (finish)                  state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt)               state_nxt = ST_READ;
      ST_READ:  if (beat && hist_bin == LAST_BIN) state_nxt = ST_DONE;
      ST_DONE:                               state_nxt = ST_DONE;
      default:                               state_nxt = ST_ACC;
    endcase
  end

  always_comb begin
    hist_valid = (state == ST_READ);
    hist_done  = (state == ST_DONE);
  end

  // Input stage: border samples are dropped here and only raise the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      addr_err <= 1'b0;
    end else begin
      s1_valid <= accept && !border;
      s1_bin   <= lbp_data;
      if (accept && border) begin
        addr_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_count <= '0;
    end else if (s1_valid && pix_count != CNT_MAX) begin
      pix_count <= pix_count + CNT_W'(1);
    end
  end

  // Two drain cycles let the last staged code reach the bank before readout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= (state == ST_DRAIN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_bin <= '0;
    end else if (beat && hist_bin != LAST_BIN) begin
      hist_bin <= hist_bin + 8'd1;
    end
  end

  hist_bank #(
    .BINS  (BINS),
    .CNT_W (CNT_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (s1_valid),
    .wr_bin   (s1_bin),
    .rd_bin   (hist_bin),
    .rd_count (rd_count)
  );

  assign hist_count = hist_valid ? rd_count : '0;

endmodule

// File: tb/tb_lbp_hist.sv
// Directed self-checking bench for lbp_hist: table of single-code vectors
// plus hand-written sequences for drain, stall, mid-readout reset and saturation.
module tb_lbp_hist;

  localparam int CNT_W = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic             lbp_valid;
  logic [13:0]      lbp_addr;
  logic [7:0]       lbp_data;
  logic             finish;
  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic [CNT_W-1:0] pix_count;
  logic             addr_err;
  logic             hist_done;

  int checks = 0;
  int errors = 0;
  int got[256];
  int exp_hist[256];
  int beats;

  typedef struct {
    int row;
    int col;
    int code;
    bit counted;
    int exp_pix;
    bit exp_err;
  } vec_t;

  vec_t vecs[9];

  lbp_hist dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .pix_count  (pix_count),
    .addr_err   (addr_err),
    .hist_done  (hist_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int row, input int col, input int code, input bit fin);
    lbp_addr  = {7'(row), 7'(col)};
    lbp_data  = 8'(code);
    lbp_valid = 1'b1;
    finish    = fin;
    @(posedge clk);
    #1;
    lbp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    lbp_valid  = 1'b0;
    lbp_addr   = '0;
    lbp_data   = '0;
    finish     = 1'b0;
    hist_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_hist[i] = 0;
  endtask

  task automatic check_hist(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (got[i] != exp_hist[i]) begin
        if (bad == 0) $display("[TB]   first differing bin %0d got %0d expected %0d", i, got[i], exp_hist[i]);
        bad++;
      end
    end
    check_output(name, bad, 0);
  endtask

  // Collect every readout beat; optionally stall at bin 7 and/or hold
  // lbp_valid high to show codes are ignored outside accumulation.
  task automatic read_all(input bit stall7, input bit poke);
    int cyc;
    int order_errs;
    bit stalled;
    bit expect8;
    logic [CNT_W-1:0] held;
    beats = 0; cyc = 0; order_errs = 0; stalled = 0; expect8 = 0;
    for (int i = 0; i < 256; i++) got[i] = -1;
    hist_ready = 1'b1;
    if (poke) begin
      lbp_valid = 1'b1;
      lbp_addr  = {7'd10, 7'd10};
      lbp_data  = 8'h10;
    end
    while (beats < 256 && cyc < 3000) begin
      if (hist_valid) begin
        if (expect8) begin
          check_output("bin_after_stall", hist_bin, 8);
          expect8 = 0;
        end
        if (stall7 && !stalled && hist_bin == 8'd7) begin
          stalled    = 1;
          held       = hist_count;
          hist_ready = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_output("stall_bin", hist_bin, 7);
            check_output("stall_count", hist_count, held);
          end
          hist_ready = 1'b1;
          expect8    = 1;
        end
        if (hist_bin != 8'(beats)) order_errs++;
        got[hist_bin] = int'(hist_count);
        beats++;
      end
      if (beats < 256) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check_output("readout_beats", beats, 256);
    check_output("readout_order", order_errs, 0);
    @(posedge clk);
    #1;
    if (poke) lbp_valid = 1'b0;
    check_output("hist_done", hist_done, 1);
    check_output("hist_valid_done", hist_valid, 0);
  endtask

  initial begin
    int seq_b[4];
    int cyc;
    reset = 1'b1;

    // Reset state
    do_reset();
    check_output("rst_hist_valid", hist_valid, 0);
    check_output("rst_hist_done", hist_done, 0);
    check_output("rst_hist_bin", hist_bin, 0);
    check_output("rst_hist_count", hist_count, 0);
    check_output("rst_pix_count", pix_count, 0);
    check_output("rst_addr_err", addr_err, 0);

    // Four back-to-back 0x5A codes
    for (int i = 1; i <= 4; i++) apply_stimulus(1, i, 8'h5A, 1'b0);
    finish = 1'b1;
    read_all(1'b0, 1'b0);
    clear_exp();
    exp_hist[8'h5A] = 4;
    check_hist("hist_5a");
    check_output("bin_5a", got[8'h5A], 4);
    check_output("pix_5a", pix_count, 4);

    // Codes 3,3,4,3 consecutively, pix_count appears two cycles after each code
    do_reset();
    seq_b = '{3, 3, 4, 3};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2, 2 + i, seq_b[i], 1'b0);
      check_output("pix_latency", pix_count, i);
    end
    @(posedge clk);
    #1;
    check_output("pix_3343", pix_count, 4);
    finish = 1'b1;
    read_all(1'b0, 1'b0);
    clear_exp();
    exp_hist[3] = 3;
    exp_hist[4] = 1;
    check_hist("hist_3343");
    check_output("bin3", got[3], 3);
    check_output("bin4", got[4], 1);

    // Table of single codes, including every border side
    do_reset();
    vecs[0] = '{row: 1,   col: 1,   code: 8'h11, counted: 1, exp_pix: 1, exp_err: 0};
    vecs[1] = '{row: 0,   col: 5,   code: 8'h10, counted: 0, exp_pix: 1, exp_err: 1};
    vecs[2] = '{row: 5,   col: 0,   code: 8'h22, counted: 0, exp_pix: 1, exp_err: 1};
    vecs[3] = '{row: 127, col: 5,   code: 8'h22, counted: 0, exp_pix: 1, exp_err: 1};
    vecs[4] = '{row: 5,   col: 127, code: 8'h22, counted: 0, exp_pix: 1, exp_err: 1};
    vecs[5] = '{row: 126, col: 126, code: 8'h22, counted: 1, exp_pix: 2, exp_err: 1};
    vecs[6] = '{row: 64,  col: 64,  code: 8'h80, counted: 1, exp_pix: 3, exp_err: 1};
    vecs[7] = '{row: 1,   col: 126, code: 8'h11, counted: 1, exp_pix: 4, exp_err: 1};
    vecs[8] = '{row: 3,   col: 3,   code: 8'h07, counted: 1, exp_pix: 5, exp_err: 1};
    clear_exp();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].row, vecs[i].col, vecs[i].code, 1'b0);
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_pix", i), pix_count, vecs[i].exp_pix);
      check_output($sformatf("vec%0d_err", i), addr_err, vecs[i].exp_err);
      if (vecs[i].counted) exp_hist[vecs[i].code]++;
    end
    apply_stimulus(2, 2, 8'h33, 1'b1);
    exp_hist[8'h33]++;
    read_all(1'b1, 1'b1);
    check_hist("hist_table");
    check_output("bin10_border", got[8'h10], 0);
    check_output("pix_table", pix_count, 6);
    check_output("err_sticky", addr_err, 1);

    // Reset in the middle of readout, then a fresh image
    do_reset();
    apply_stimulus(4, 4, 8'h01, 1'b0);
    apply_stimulus(4, 5, 8'h01, 1'b0);
    apply_stimulus(4, 6, 8'h01, 1'b0);
    apply_stimulus(4, 7, 8'h5A, 1'b0);
    finish = 1'b1;
    cyc = 0;
    while (!(hist_valid && hist_bin == 8'd3) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output("reach_bin3", hist_bin, 3);
    #2;
    reset = 1'b1;
    #1;
    check_output("midrst_hist_valid", hist_valid, 0);
    check_output("midrst_hist_bin", hist_bin, 0);
    check_output("midrst_hist_count", hist_count, 0);
    check_output("midrst_pix", pix_count, 0);
    check_output("midrst_done", hist_done, 0);
    finish    = 1'b0;
    lbp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus(5, 5, 8'h01, 1'b0);
    apply_stimulus(5, 6, 8'h01, 1'b0);
    finish = 1'b1;
    read_all(1'b0, 1'b0);
    clear_exp();
    exp_hist[1] = 2;
    check_hist("hist_after_rst");
    check_output("bin1_after_rst", got[1], 2);

    // Full 126x126 raster of 0xFF, last code coincident with finish
    do_reset();
    for (int r = 1; r <= 126; r++)
      for (int c = 1; c <= 126; c++)
        apply_stimulus(r, c, 8'hFF, (r == 126) && (c == 126));
    read_all(1'b0, 1'b0);
    clear_exp();
    exp_hist[255] = 15876;
    check_hist("hist_raster");
    check_output("bin255_raster", got[255], 15876);
    check_output("pix_raster", pix_count, 15876);
    repeat (5) @(posedge clk);
    #1;
    check_output("done_held", hist_done, 1);

    // More codes than a counter can hold: bin and pix_count stop at 16383
    do_reset();
    for (int i = 0; i < 16390; i++)
      apply_stimulus(1 + (i / 126) % 126, 1 + i % 126, 8'h00, 1'b0);
    finish = 1'b1;
    read_all(1'b0, 1'b0);
    clear_exp();
    exp_hist[0] = 16383;
    check_hist("hist_sat");
    check_output("bin0_sat", got[0], 16383);
    check_output("pix_sat", pix_count, 16383);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
